// File: rtl/bexkat1Def.sv
// bexkat1Def: shared constants for the bexkat1 register file and writeback path.
//   REG_WRITE_DATA / REG_WRITE_SP : bit positions inside the 2-bit reg_write field.
//   REG_SP                        : architectural index of the stack pointer (r15).
//   REG_ADDR_W / DATA_W / CNT_W   : common field widths.
package bexkat1Def;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 16;
    localparam int NREGS      = 16;

    localparam int REG_WRITE_DATA = 0;
    localparam int REG_WRITE_SP   = 1;

    localparam logic [REG_ADDR_W-1:0] REG_SP = 4'd15;

    // Bank index width; a single-bank file still carries one (constant) bit.
    function automatic int bank_w(input int nbanks);
        return (nbanks > 1) ? $clog2(nbanks) : 1;
    endfunction

endpackage

// File: rtl/bexkat1_regfile_rdport.sv
// bexkat1_regfile_rdport: one combinational read port with write-through bypass.
//   regs_i       : full storage array (all banks, all registers).
//   rd_bank_i    : bank to read (already truncated to the implemented width).
//   rd_addr_i    : register to read.
//   we_data_i    : explicit register write will commit at the next edge.
//   we_sp_i      : stack-pointer write will commit at the next edge.
//   wb_bank_i    : bank of the pending write.
//   wb_addr_i    : destination of the pending explicit write.
//   wb_data_i    : data of the pending explicit write.
//   sp_data_i    : data of the pending stack-pointer write.
//   rd_o         : read data.
module bexkat1_regfile_rdport
    import bexkat1Def::*;
#(
    parameter int NBANKS = 2,
    parameter int BW     = 1
) (
    input  logic [DATA_W-1:0]     regs_i [NBANKS][NREGS],
    input  logic [BW-1:0]         rd_bank_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  we_data_i,
    input  logic                  we_sp_i,
    input  logic [BW-1:0]         wb_bank_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic [DATA_W-1:0]     sp_data_i,
    output logic [DATA_W-1:0]     rd_o
);

    always_comb begin
        rd_o = regs_i[rd_bank_i][rd_addr_i];
        if (rd_bank_i == wb_bank_i) begin
            // Same order as the commit: the SP write first, then the explicit
            // write overrides it when both target r15.
            if (we_sp_i && (rd_addr_i == REG_SP)) begin
                rd_o = sp_data_i;
            end
            if (we_data_i && (rd_addr_i == wb_addr_i)) begin
                rd_o = wb_data_i;
            end
        end
    end

endmodule

// File: rtl/bexkat1_regfile.sv
// bexkat1_regfile: banked 16x32 register file, writeback sink of the pipeline.
//   clk_i, rst_i      : clock; asynchronous active-high reset.
//   halt_i            : halting instruction retires with this beat.
//   reg_write_i       : bit0 = write wb_data_i to wb_addr_i, bit1 = write sp_data_i to r15.
//   wb_addr_i/_data_i : explicit write destination and data.
//   sp_data_i         : new stack pointer.
//   wb_bank_i         : bank for the write (low bits only).
//   rd_bank_i         : bank for all reads (low bits only).
//   rd1/rd2_addr_i    : read port addresses; rd1_o/rd2_o the data.
//   sp_o              : r15 of rd_bank_i.
//   halted_o          : a halt has retired; writes are frozen until reset.
//   wr_count_o        : number of committed write beats (wraps).
module bexkat1_regfile
    import bexkat1Def::*;
#(
    parameter int          NBANKS   = 2,
    parameter logic [31:0] SP_RESET = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  halt_i,
    input  logic [1:0]            reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic [DATA_W-1:0]     sp_data_i,
    input  logic [3:0]            wb_bank_i,
    input  logic [3:0]            rd_bank_i,
    input  logic [REG_ADDR_W-1:0] rd1_addr_i,
    input  logic [REG_ADDR_W-1:0] rd2_addr_i,
    output logic [DATA_W-1:0]     rd1_o,
    output logic [DATA_W-1:0]     rd2_o,
    output logic [DATA_W-1:0]     sp_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      wr_count_o
);

    localparam int BW = bank_w(NBANKS);

    logic [DATA_W-1:0] regs_q [NBANKS][NREGS];
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic [BW-1:0] wb_bank, rd_bank;
    logic          we_data, we_sp;
    logic          unused_bank_bits;

    // High bank bits are ignored, so out-of-range banks alias lower ones.
    assign wb_bank = (NBANKS > 1) ? wb_bank_i[BW-1:0] : '0;
    assign rd_bank = (NBANKS > 1) ? rd_bank_i[BW-1:0] : '0;
    assign unused_bank_bits = ^{wb_bank_i, rd_bank_i};

    // Once halted, nothing commits and nothing bypasses.
    assign we_data = reg_write_i[REG_WRITE_DATA] & ~halted_q;
    assign we_sp   = reg_write_i[REG_WRITE_SP]   & ~halted_q;

    always_comb begin
        halted_d   = halted_q;
        wr_count_d = wr_count_q;
        if (!halted_q) begin
            if (reg_write_i != 2'b00) begin
                wr_count_d = wr_count_q + 1'b1;
            end
            if (halt_i) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halted_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            halted_q   <= halted_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < NREGS; r++) begin
                    regs_q[b][r] <= (r == int'(REG_SP)) ? SP_RESET : '0;
                end
            end
        end else begin
            if (we_sp) begin
                regs_q[wb_bank][REG_SP] <= sp_data_i;
            end
            // Issued after the SP write so it wins when wb_addr_i is r15.
            if (we_data) begin
                regs_q[wb_bank][wb_addr_i] <= wb_data_i;
            end
        end
    end

    bexkat1_regfile_rdport #(.NBANKS(NBANKS), .BW(BW)) u_rd1 (
        .regs_i    (regs_q),
        .rd_bank_i (rd_bank),
        .rd_addr_i (rd1_addr_i),
        .we_data_i (we_data),
        .we_sp_i   (we_sp),
        .wb_bank_i (wb_bank),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .sp_data_i (sp_data_i),
        .rd_o      (rd1_o)
    );

    bexkat1_regfile_rdport #(.NBANKS(NBANKS), .BW(BW)) u_rd2 (
        .regs_i    (regs_q),
        .rd_bank_i (rd_bank),
        .rd_addr_i (rd2_addr_i),
        .we_data_i (we_data),
        .we_sp_i   (we_sp),
        .wb_bank_i (wb_bank),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .sp_data_i (sp_data_i),
        .rd_o      (rd2_o)
    );

    bexkat1_regfile_rdport #(.NBANKS(NBANKS), .BW(BW)) u_sp (
        .regs_i    (regs_q),
        .rd_bank_i (rd_bank),
        .rd_addr_i (REG_SP),
        .we_data_i (we_data),
        .we_sp_i   (we_sp),
        .wb_bank_i (wb_bank),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .sp_data_i (sp_data_i),
        .rd_o      (sp_o)
    );

    assign halted_o   = halted_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_bexkat1_regfile.sv
module tb_bexkat1_regfile;

    localparam logic [31:0] SP_RST = 32'h0007_FFF0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        halt_i = 1'b0;
    logic [1:0]  reg_write_i = 2'b00;
    logic [3:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [31:0] sp_data_i = '0;
    logic [3:0]  wb_bank_i = '0;
    logic [3:0]  rd_bank_i = '0;
    logic [3:0]  rd1_addr_i = '0;
    logic [3:0]  rd2_addr_i = '0;
    logic [31:0] rd1_o, rd2_o, sp_o;
    logic        halted_o;
    logic [15:0] wr_count_o;

    int n_checks = 0;
    int n_errors = 0;

    bexkat1_regfile #(.NBANKS(2), .SP_RESET(SP_RST)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .halt_i     (halt_i),
        .reg_write_i(reg_write_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .sp_data_i  (sp_data_i),
        .wb_bank_i  (wb_bank_i),
        .rd_bank_i  (rd_bank_i),
        .rd1_addr_i (rd1_addr_i),
        .rd2_addr_i (rd2_addr_i),
        .rd1_o      (rd1_o),
        .rd2_o      (rd2_o),
        .sp_o       (sp_o),
        .halted_o   (halted_o),
        .wr_count_o (wr_count_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        halt;
        logic [1:0]  rw;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] sp_data;
        logic [3:0]  wb_bank;
        logic [3:0]  rd_bank;
        logic [3:0]  rd1_addr;
        logic [3:0]  rd2_addr;
        logic [31:0] exp_rd1_pre;
        logic [31:0] exp_rd2_pre;
        logic [31:0] exp_sp_pre;
        logic [31:0] exp_rd1_post;
        logic [31:0] exp_rd2_post;
        logic [31:0] exp_sp_post;
        logic        exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    // ---------------- driver ----------------
    // Drive a beat after the falling edge, check same-cycle (bypass) reads,
    // let it commit, then drop the write and check stored reads.
    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk_i);
        halt_i      = v.halt;
        reg_write_i = v.rw;
        wb_addr_i   = v.wb_addr;
        wb_data_i   = v.wb_data;
        sp_data_i   = v.sp_data;
        wb_bank_i   = v.wb_bank;
        rd_bank_i   = v.rd_bank;
        rd1_addr_i  = v.rd1_addr;
        rd2_addr_i  = v.rd2_addr;
        #1;
        check($sformatf("v%0d rd1_pre", idx), rd1_o, v.exp_rd1_pre);
        check($sformatf("v%0d rd2_pre", idx), rd2_o, v.exp_rd2_pre);
        check($sformatf("v%0d sp_pre", idx),  sp_o,  v.exp_sp_pre);
        @(posedge clk_i);
        #1;
        halt_i      = 1'b0;
        reg_write_i = 2'b00;
        #1;
        check($sformatf("v%0d rd1_post", idx), rd1_o, v.exp_rd1_post);
        check($sformatf("v%0d rd2_post", idx), rd2_o, v.exp_rd2_post);
        check($sformatf("v%0d sp_post", idx),  sp_o,  v.exp_sp_post);
        check($sformatf("v%0d halted", idx),   {31'd0, halted_o}, {31'd0, v.exp_halted});
        check($sformatf("v%0d count", idx),    {16'd0, wr_count_o}, {16'd0, v.exp_cnt});
    endtask

    task automatic write_beat(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        halt_i      = 1'b0;
        reg_write_i = 2'b01;
        wb_addr_i   = addr;
        wb_data_i   = data;
        wb_bank_i   = 4'h0;
        @(posedge clk_i);
        #1;
        reg_write_i = 2'b00;
    endtask

    initial begin
        //           halt rw     addr  wb_data        sp_data       wbk   rbk   a1    a2    rd1_pre       rd2_pre       sp_pre        rd1_post      rd2_post      sp_post       h     cnt
        vecs[0] = '{1'b0, 2'b01, 4'd5, 32'hDEADBEEF, 32'h0,       4'h0, 4'h0, 4'd5, 4'd3, 32'hDEADBEEF, 32'h0,       SP_RST,       32'hDEADBEEF, 32'h0,       SP_RST,       1'b0, 16'd1};
        vecs[1] = '{1'b0, 2'b00, 4'd0, 32'h0,        32'h0,       4'h0, 4'h1, 4'd5, 4'd15, 32'h0,       SP_RST,       SP_RST,       32'h0,        SP_RST,       SP_RST,       1'b0, 16'd1};
        vecs[2] = '{1'b0, 2'b11, 4'd15, 32'h1111,    32'h2222,    4'h0, 4'h0, 4'd15, 4'd5, 32'h1111,    32'hDEADBEEF, 32'h1111,     32'h1111,     32'hDEADBEEF, 32'h1111,     1'b0, 16'd2};
        vecs[3] = '{1'b0, 2'b10, 4'd0, 32'h0,        32'h100,     4'h1, 4'h1, 4'd15, 4'd0, 32'h100,     32'h0,        32'h100,      32'h100,      32'h0,        32'h100,      1'b0, 16'd3};
        vecs[4] = '{1'b0, 2'b00, 4'd0, 32'h0,        32'h0,       4'h0, 4'h0, 4'd15, 4'd5, 32'h1111,    32'hDEADBEEF, 32'h1111,     32'h1111,     32'hDEADBEEF, 32'h1111,     1'b0, 16'd3};
        vecs[5] = '{1'b0, 2'b01, 4'd1, 32'h5,        32'h0,       4'h3, 4'h1, 4'd1, 4'd15, 32'h5,       32'h100,      32'h100,      32'h5,        32'h100,      32'h100,      1'b0, 16'd4};
        vecs[6] = '{1'b0, 2'b01, 4'd0, 32'hA5A5,     32'h0,       4'h0, 4'h1, 4'd0, 4'd1, 32'h0,        32'h5,        32'h100,      32'h0,        32'h5,        32'h100,      1'b0, 16'd5};
        vecs[7] = '{1'b0, 2'b00, 4'd0, 32'h0,        32'h0,       4'h0, 4'h0, 4'd0, 4'd2, 32'hA5A5,     32'h0,        32'h1111,     32'hA5A5,     32'h0,        32'h1111,     1'b0, 16'd5};
        vecs[8] = '{1'b0, 2'b01, 4'd15, 32'h12345678, 32'h0,      4'h0, 4'h0, 4'd15, 4'd0, 32'h12345678, 32'hA5A5,    32'h12345678, 32'h12345678, 32'hA5A5,     32'h12345678, 1'b0, 16'd6};

        // ---- reset state ----
        rd1_addr_i = 4'd3;
        rd_bank_i  = 4'h0;
        #12;
        check("rst rd1", rd1_o, 32'h0);
        check("rst sp bank0", sp_o, SP_RST);
        check("rst halted", {31'd0, halted_o}, 32'h0);
        check("rst count", {16'd0, wr_count_o}, 32'h0);
        rd_bank_i = 4'h1;
        #1;
        check("rst sp bank1", sp_o, SP_RST);
        @(negedge clk_i);
        rst_i = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 9; i++) begin
            apply_vec(i, vecs[i]);
        end

        // ---- halt beat that also writes r2=7 ----
        @(negedge clk_i);
        halt_i      = 1'b1;
        reg_write_i = 2'b01;
        wb_addr_i   = 4'd2;
        wb_data_i   = 32'h7;
        wb_bank_i   = 4'h0;
        rd_bank_i   = 4'h0;
        rd1_addr_i  = 4'd2;
        rd2_addr_i  = 4'd15;
        #1;
        check("halt rd1_pre", rd1_o, 32'h7);
        @(posedge clk_i);
        #1;
        halt_i      = 1'b0;
        reg_write_i = 2'b00;
        #1;
        check("halt rd1_post", rd1_o, 32'h7);
        check("halt halted", {31'd0, halted_o}, 32'h1);
        check("halt count", {16'd0, wr_count_o}, 32'd7);

        // ---- writes while halted are ignored, no bypass ----
        @(negedge clk_i);
        reg_write_i = 2'b11;
        wb_addr_i   = 4'd2;
        wb_data_i   = 32'h9;
        sp_data_i   = 32'hBAD0;
        #1;
        check("halted rd1_nobypass", rd1_o, 32'h7);
        check("halted sp_nobypass", sp_o, 32'h12345678);
        @(posedge clk_i);
        #1;
        reg_write_i = 2'b00;
        #1;
        check("halted rd1_kept", rd1_o, 32'h7);
        check("halted sp_kept", sp_o, 32'h12345678);
        check("halted count_frozen", {16'd0, wr_count_o}, 32'd7);
        check("halted stays", {31'd0, halted_o}, 32'h1);

        // ---- asynchronous reset mid-halt, away from any edge ----
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst rd1", rd1_o, 32'h0);
        check("arst rd2_r15", rd2_o, SP_RST);
        check("arst sp", sp_o, SP_RST);
        check("arst halted", {31'd0, halted_o}, 32'h0);
        check("arst count", {16'd0, wr_count_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // ---- counter wrap ----
        for (int i = 0; i < 65535; i++) begin
            write_beat(4'd3, 32'(i));
        end
        check("wrap count_ffff", {16'd0, wr_count_o}, 32'h0000_FFFF);
        write_beat(4'd3, 32'h0001_0000);
        check("wrap count_zero", {16'd0, wr_count_o}, 32'h0);
        rd1_addr_i = 4'd3;
        rd_bank_i  = 4'h0;
        #1;
        check("wrap r3_last", rd1_o, 32'h0001_0000);
        check("wrap not_halted", {31'd0, halted_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
